// File: rtl/dc_pkg.sv
// dc_pkg: shared definitions for the microcode sequencer.
//   - seq_op encodings (NEXT/JUMP/CALL/RET)
//   - sequencer state encoding (INIT/RUN/HOLD)
//   - default reset and trap microaddresses, address/word widths
package dc_pkg;

    localparam int UA_W      = 9;   // microaddress width (without AX page bit)
    localparam int MC_W      = 16;  // microinstruction word width
    localparam int STK_DEPTH = 2;   // return stack depth

    localparam logic [UA_W-1:0] DC_RST_VEC  = 9'h100;
    localparam logic [UA_W-1:0] DC_TRAP_VEC = 9'h104;

    typedef enum logic [1:0] {
        SEQ_NEXT = 2'b00,
        SEQ_JUMP = 2'b01,
        SEQ_CALL = 2'b10,
        SEQ_RET  = 2'b11
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/dc_ustk.sv
// dc_ustk: two-entry microcode return stack.
//   clk     : clock, rising edge
//   nrst    : synchronous active-low reset (empties stack, clears err)
//   push_i  : push din_i; when full the oldest entry is dropped
//   pop_i   : pop the top entry; when empty nothing changes
//   din_i   : return address to push
//   top_o   : current top entry (valid when !empty_o)
//   empty_o : no entries held
//   full_o  : STK_DEPTH entries held
//   err_o   : sticky overflow/underflow flag
module dc_ustk
    import dc_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [UA_W-1:0] din_i,
    output logic [UA_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            err_o
);

    // ent_q[0] is the top of stack, ent_q[1] the older entry.
    logic [UA_W-1:0] ent_q [STK_DEPTH];
    logic [UA_W-1:0] ent_d [STK_DEPTH];
    logic [1:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    assign top_o   = ent_q[0];
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'(STK_DEPTH));
    assign err_o   = err_q;

    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push_i) begin
            // Shifting down drops the oldest entry when already full.
            ent_d[1] = ent_q[0];
            ent_d[0] = din_i;
            if (full_o) err_d = 1'b1;
            else        cnt_d = cnt_q + 2'd1;
        end else if (pop_i) begin
            if (empty_o) begin
                err_d = 1'b1;
            end else begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/dc_seq.sv
// dc_seq: microcode sequencer driving an external MicROM.
//   clk      : clock, all state changes on rising edge
//   nrst     : synchronous active-low reset
//   rom_a    : MicROM address {ax_q, upc}, registered
//   rom_ma   : next-address field of the current ROM word
//   rom_mc   : opcode field of the current ROM word
//   ax       : AX page select for the next fetch
//   stall    : datapath hold request
//   seq_op   : 00 NEXT, 01 JUMP, 10 CALL, 11 RET
//   jmp_addr : JUMP/CALL target
//   trap_req : level trap request
//   trap_ack : one-cycle pulse in the cycle after a trap is taken
//   mir      : microinstruction register
//   mir_vld  : mir holds a valid word
//   stk_err  : sticky return stack overflow/underflow
module dc_seq
    import dc_pkg::*;
#(
    parameter logic [UA_W-1:0] RST_VEC  = DC_RST_VEC,
    parameter logic [UA_W-1:0] TRAP_VEC = DC_TRAP_VEC
) (
    input  logic            clk,
    input  logic            nrst,
    output logic [UA_W:0]   rom_a,
    input  logic [UA_W-1:0] rom_ma,
    input  logic [MC_W-1:0] rom_mc,
    input  logic            ax,
    input  logic            stall,
    input  logic [1:0]      seq_op,
    input  logic [UA_W-1:0] jmp_addr,
    input  logic            trap_req,
    output logic            trap_ack,
    output logic [MC_W-1:0] mir,
    output logic            mir_vld,
    output logic            stk_err
);

    state_e          state_q, state_d;
    logic [UA_W-1:0] upc_q, upc_d;
    logic            ax_q, ax_d;
    logic [MC_W-1:0] mir_q, mir_d;
    logic            vld_q, vld_d;
    logic            ack_q, ack_d;

    logic            stk_push, stk_pop;
    logic [UA_W-1:0] stk_top;
    logic            stk_empty, stk_full;

    dc_ustk u_ustk (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (rom_ma),
        .top_o   (stk_top),
        .empty_o (stk_empty),
        .full_o  (stk_full),
        .err_o   (stk_err)
    );

    // Only registers reach the ROM address.
    assign rom_a    = {ax_q, upc_q};
    assign mir      = mir_q;
    assign mir_vld  = vld_q;
    assign trap_ack = ack_q;

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        ax_d     = ax_q;
        mir_d    = mir_q;
        vld_d    = vld_q;
        ack_d    = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        case (state_q)
            ST_INIT: begin
                // ROM is presenting the RST_VEC word.
                mir_d   = rom_mc;
                vld_d   = 1'b1;
                upc_d   = rom_ma;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (stall) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                    mir_d   = rom_mc;
                    ax_d    = ax;
                    if (trap_req) begin
                        // Trap overrides sequencing; no stack traffic.
                        upc_d = TRAP_VEC;
                        ax_d  = 1'b0;
                        ack_d = 1'b1;
                    end else begin
                        case (seq_op_e'(seq_op))
                            SEQ_RET: begin
                                // Empty-stack RET falls back to the ROM link.
                                stk_pop = 1'b1;
                                upc_d   = stk_empty ? rom_ma : stk_top;
                            end
                            SEQ_JUMP: upc_d = jmp_addr;
                            SEQ_CALL: begin
                                stk_push = 1'b1;
                                upc_d    = jmp_addr;
                            end
                            default:  upc_d = rom_ma;
                        endcase
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_INIT;
            upc_q   <= RST_VEC;
            ax_q    <= 1'b0;
            mir_q   <= '0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ax_q    <= ax_d;
            mir_q   <= mir_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_dc_seq.sv
module tb_dc_seq;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [9:0]  rom_a;
    logic [8:0]  rom_ma;
    logic [15:0] rom_mc;
    logic        ax = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  seq_op = 2'b00;
    logic [8:0]  jmp_addr = 9'h0;
    logic        trap_req = 1'b0;
    logic        trap_ack;
    logic [15:0] mir;
    logic        mir_vld;
    logic        stk_err;

    always #5 clk = ~clk;

    dc_seq dut (
        .clk      (clk),
        .nrst     (nrst),
        .rom_a    (rom_a),
        .rom_ma   (rom_ma),
        .rom_mc   (rom_mc),
        .ax       (ax),
        .stall    (stall),
        .seq_op   (seq_op),
        .jmp_addr (jmp_addr),
        .trap_req (trap_req),
        .trap_ack (trap_ack),
        .mir      (mir),
        .mir_vld  (mir_vld),
        .stk_err  (stk_err)
    );

    // MicROM model: {ma[8:0], mc[15:0]}
    logic [24:0] rom_mem [1024];
    assign rom_ma = rom_mem[rom_a][24:16];
    assign rom_mc = rom_mem[rom_a][15:0];

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] mir;
        logic        vld;
        logic        ack;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: architectural state only
    bit         m_init;
    logic [8:0] m_upc;
    logic       m_ax;
    logic [15:0] m_mir;
    logic       m_vld, m_ack, m_err;
    logic [8:0] m_stk[$];   // back = top

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: DUT presents a fresh output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rom_a",    32'(rom_a),    32'(e.a));
                chk("mir",      32'(mir),      32'(e.mir));
                chk("mir_vld",  32'(mir_vld),  32'(e.vld));
                chk("trap_ack", 32'(trap_ack), 32'(e.ack));
                chk("stk_err",  32'(stk_err),  32'(e.err));
            end
        end
    end

    // Drive one cycle of inputs, advance the model, queue expected outputs.
    task automatic step(input logic n, input logic st, input logic tr, input logic a,
                        input logic [1:0] op, input logic [8:0] ja);
        logic [9:0] ra;
        logic [8:0] ma;
        logic [15:0] mc;
        @(negedge clk);
        nrst = n; stall = st; trap_req = tr; ax = a; seq_op = op; jmp_addr = ja;
        ra = {m_ax, m_upc};
        ma = rom_mem[ra][24:16];
        mc = rom_mem[ra][15:0];
        m_ack = 1'b0;
        if (!n) begin
            m_init = 1; m_upc = 9'h100; m_ax = 0; m_mir = 0; m_vld = 0;
            m_err = 0; m_stk.delete();
        end else if (m_init) begin
            m_init = 0; m_mir = mc; m_vld = 1; m_upc = ma;
        end else if (!st) begin
            m_mir = mc;
            if (tr) begin
                m_upc = 9'h104; m_ax = 0; m_ack = 1;
            end else begin
                m_ax = a;
                case (op)
                    2'b11: begin
                        if (m_stk.size() == 0) begin m_upc = ma; m_err = 1; end
                        else m_upc = m_stk.pop_back();
                    end
                    2'b01: m_upc = ja;
                    2'b10: begin
                        if (m_stk.size() == 2) begin void'(m_stk.pop_front()); m_err = 1; end
                        m_stk.push_back(ma);
                        m_upc = ja;
                    end
                    default: m_upc = ma;
                endcase
            end
        end
        exp_q.push_back('{a: {m_ax, m_upc}, mir: m_mir, vld: m_vld, ack: m_ack, err: m_err});
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] cap_mir;
        logic [9:0]  cap_a;
        logic [9:0]  pre;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 25'($urandom);
        rom_mem[10'h100] = {9'h101, 16'hA5A5};
        m_init = 1; m_upc = 9'h100; m_ax = 0; m_mir = 0; m_vld = 0; m_ack = 0; m_err = 0;

        // Reset release and first fetch
        step(0, 1, 1, 1, 2'b10, 9'h0);
        step(0, 0, 0, 0, 2'b00, 9'h0);
        chk("init_rom_a", 32'(rom_a), 32'h100);
        chk("init_vld",   32'(mir_vld), 32'h0);
        step(1, 0, 0, 0, 2'b00, 9'h0);
        chk("first_mir",   32'(mir), 32'hA5A5);
        chk("first_vld",   32'(mir_vld), 32'h1);
        chk("first_rom_a", 32'(rom_a), 32'h101);

        // CALL then RET
        rom_mem[10'h101][24:16] = 9'h123;
        step(1, 0, 0, 0, 2'b10, 9'h040);
        chk("call_upc", 32'(rom_a), 32'h040);
        step(1, 0, 0, 0, 2'b11, 9'h000);
        chk("ret_upc", 32'(rom_a), 32'h123);
        chk("ret_err", 32'(stk_err), 32'h0);

        // Three nested CALLs, three RETs
        step(1, 0, 0, 0, 2'b10, 9'h050);
        step(1, 0, 0, 0, 2'b10, 9'h060);
        chk("call2_err", 32'(stk_err), 32'h0);
        step(1, 0, 0, 0, 2'b10, 9'h070);
        chk("call3_err", 32'(stk_err), 32'h1);
        step(1, 0, 0, 0, 2'b11, 9'h000);
        step(1, 0, 0, 0, 2'b11, 9'h000);
        pre = {m_ax, m_upc};
        step(1, 0, 0, 0, 2'b11, 9'h000);
        chk("ret3_rom_ma", 32'(rom_a), 32'({1'b0, rom_mem[pre][24:16]}));

        // Stall for 4 cycles, trap rising mid-stall
        step(0, 0, 0, 0, 2'b00, 9'h0);
        step(1, 0, 0, 0, 2'b00, 9'h0);
        step(1, 0, 0, 0, 2'b00, 9'h0);
        cap_mir = mir; cap_a = rom_a;
        chk("pre_stall_mir", 32'(cap_mir), 32'(m_mir));
        for (int i = 0; i < 4; i++) begin
            step(1, 1, (i >= 2), 0, 2'b10, 9'h0AA);
            chk("stall_mir",   32'(mir), 32'(cap_mir));
            chk("stall_rom_a", 32'(rom_a), 32'(cap_a));
            chk("stall_ack",   32'(trap_ack), 32'h0);
        end
        step(1, 0, 1, 1, 2'b10, 9'h0AA);
        chk("resume_ack",   32'(trap_ack), 32'h1);
        chk("resume_rom_a", 32'(rom_a), 32'h104);
        step(1, 0, 0, 0, 2'b00, 9'h0);
        chk("ack_pulse", 32'(trap_ack), 32'h0);

        // AX page select then trap
        rom_mem[{m_ax, m_upc}][24:16] = 9'h1F3;
        step(1, 0, 0, 1, 2'b00, 9'h0);
        chk("ax_rom_a", 32'(rom_a), 32'h3F3);
        step(1, 0, 1, 1, 2'b11, 9'h0);
        chk("ax_trap_rom_a", 32'(rom_a), 32'h104);

        // Reset during HOLD with one stack entry
        step(1, 0, 0, 0, 2'b10, 9'h033);
        step(1, 1, 0, 0, 2'b00, 9'h0);
        step(0, 1, 1, 0, 2'b11, 9'h0);
        chk("hold_rst_mir",   32'(mir), 32'h0);
        chk("hold_rst_vld",   32'(mir_vld), 32'h0);
        chk("hold_rst_rom_a", 32'(rom_a), 32'h100);
        step(1, 0, 0, 0, 2'b00, 9'h0);
        step(1, 0, 0, 0, 2'b11, 9'h0);
        chk("rst_ret_err", 32'(stk_err), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 9'($urandom_range(0, 511)));
        end

        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dc_seq.md
DC_SEQ -- requirements
Module: dc_seq

Interface
REQ-001 SHALL have parameter RST_VEC, default 9'h100, microaddress fetched first after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 9'h104, microaddress entered on an accepted trap.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port rom_a, output, 10, MicROM address: {ax_q, upc}.
REQ-006 SHALL have port rom_ma, input, 9, next-address field of the current ROM word.
REQ-007 SHALL have port rom_mc, input, 16, opcode field of the current ROM word.
REQ-008 SHALL have port ax, input, 1, AX page select for the next fetch.
REQ-009 SHALL have port stall, input, 1, hold request from the datapath (bus wait).
REQ-010 SHALL have port seq_op, input, 2, sequencing: 00 NEXT, 01 JUMP, 10 CALL, 11 RET.
REQ-011 SHALL have port jmp_addr, input, 9, target for JUMP/CALL (PLA mapping address).
REQ-012 SHALL have port trap_req, input, 1, level trap request.
REQ-013 SHALL have port trap_ack, output, 1, one-cycle pulse when a trap is taken.
REQ-014 SHALL have port mir, output, 16, microinstruction register.
REQ-015 SHALL have port mir_vld, output, 1, mir holds a valid word.
REQ-016 SHALL have port stk_err, output, 1, sticky stack overflow/underflow flag.

Function
REQ-017 SHALL implement states INIT, RUN, HOLD.
REQ-018 INIT: upc=RST_VEC, ax_q=0, mir_vld=0; SHALL move to RUN unconditionally on the next edge, loading mir<=rom_mc (word at RST_VEC), mir_vld<=1, upc<=rom_ma.
REQ-019 RUN, stall=0: each edge SHALL load mir<=rom_mc, ax_q<=ax, upc<=next address; one microinstruction per cycle, ROM-to-mir latency one edge.
REQ-020 Next-address priority SHALL be: trap_req > seq_op=RET > JUMP/CALL > NEXT (rom_ma).
REQ-021 CALL SHALL push rom_ma onto the return stack and select jmp_addr in the same cycle.
REQ-022 RET SHALL select and pop the stack top; JUMP SHALL select jmp_addr without stack effect.
REQ-023 Trap SHALL select TRAP_VEC, assert trap_ack for exactly that cycle, ignore seq_op (no push/pop), and force ax_q<=0.
REQ-024 RUN, stall=1: SHALL go to HOLD; upc, ax_q, mir, stack frozen; mir_vld stays 1; no trap_ack, no push/pop.
REQ-025 HOLD SHALL keep everything frozen while stall=1 and SHALL return to RUN and resume REQ-019 on the first edge with stall=0; a trap pending during stall is taken on that resume edge.
REQ-026 Return stack depth SHALL be 2; push when full SHALL discard the oldest entry and set stk_err.
REQ-027 RET when empty SHALL select rom_ma instead, leave the stack empty and set stk_err.
REQ-028 stk_err SHALL stay set until reset.
REQ-029 Upper 9-bit address arithmetic SHALL be pure selection; no increment, no wrap logic.
REQ-030 rom_a SHALL be driven from registers only (no combinational path from any input).

Reset
REQ-031 nrst=0 at an edge SHALL force INIT, upc=RST_VEC, ax_q=0, mir=16'h0000, mir_vld=0, trap_ack=0, stack empty, stk_err=0, overriding stall, trap_req, and any operation in progress.
REQ-032 Reset asserted in HOLD or mid-CALL SHALL leave no stack or mir residue.

Structure
REQ-033 Package dc_pkg SHALL hold seq_op encodings, state encoding, and default RST_VEC/TRAP_VEC constants.
REQ-034 The return stack SHALL be a sub-module dc_ustk (push, pop, top, empty, full, err).
REQ-035 The block SHALL contain no ROM; it connects to the MicROM through rom_a/rom_ma/rom_mc.

Verification
REQ-036 Reset release, ROM model with RST_VEC word ma=9'h101, mc=16'hA5A5: rom_a=10'h100 in INIT; next edge mir=16'hA5A5, mir_vld=1; rom_a=10'h101.
REQ-037 CALL to 9'h040 with rom_ma=9'h123, then RET: upc goes 9'h040, then 9'h123; stk_err=0.
REQ-038 Three nested CALLs, then three RETs: stk_err=1 after the third push; the third RET selects rom_ma.
REQ-039 stall high for 4 cycles with trap_req rising mid-stall: mir/rom_a constant; trap_ack pulses once on the resume edge; rom_a=10'h104.
REQ-040 ax=1 on a NEXT cycle with rom_ma=9'h1F3: rom_a=10'h3F3; subsequent trap: rom_a=10'h104.
REQ-041 nrst low during HOLD with one stack entry: INIT state, mir=0, mir_vld=0; a following RET sets stk_err (stack empty).
